// File: rtl/av_master_arbiter.sv
// Two-requester arbiter for a single Avalon-MM master port with a per-transfer watchdog.
// The winning request is registered onto m_*; completion/abort is routed back combinationally.
module av_master_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] ABORT_RDATA    = 16'hDEAD
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [15:0] req0_address,
    input  logic [15:0] req0_writedata,
    input  logic        req0_write,
    input  logic        req0_read,
    output logic [15:0] req0_readdata,
    output logic        req0_waitrequest,
    input  logic [15:0] req1_address,
    input  logic [15:0] req1_writedata,
    input  logic        req1_write,
    input  logic        req1_read,
    output logic [15:0] req1_readdata,
    output logic        req1_waitrequest,
    output logic [15:0] m_address,
    output logic [15:0] m_writedata,
    output logic        m_write,
    output logic        m_read,
    input  logic [15:0] m_readdata,
    input  logic        m_waitrequest,
    output logic        owner,
    output logic        busy,
    output logic        timeout_flag,
    input  logic        timeout_clear
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] m_address_q, m_address_d;
    logic [DW-1:0] m_writedata_q, m_writedata_d;
    logic          m_write_q, m_write_d;
    logic          m_read_q, m_read_d;
    logic [CW-1:0] count_q, count_d;
    logic          timeout_flag_q, timeout_flag_d;

    logic          act0_c, act1_c, sel_c, done_c, abort_c, fin_c;
    logic [DW-1:0] resp_c;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q        <= IDLE;
            owner_q        <= 1'b1;
            busy_q         <= 1'b0;
            m_address_q    <= '0;
            m_writedata_q  <= '0;
            m_write_q      <= 1'b0;
            m_read_q       <= 1'b0;
            count_q        <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            busy_q         <= busy_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            m_write_q      <= m_write_d;
            m_read_q       <= m_read_d;
            count_q        <= count_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // Arbitration, capture, watchdog and sticky abort flag
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        busy_d         = busy_q;
        m_address_d    = m_address_q;
        m_writedata_d  = m_writedata_q;
        m_write_d      = m_write_q;
        m_read_d       = m_read_q;
        count_d        = count_q;
        act0_c         = req0_write | req0_read;
        act1_c         = req1_write | req1_read;
        sel_c          = (act0_c & act1_c) ? ~owner_q : act1_c;
        done_c         = (state_q == BUSY) & ~m_waitrequest;
        abort_c        = (state_q == BUSY) & m_waitrequest & (count_q == LAST_CNT);
        fin_c          = done_c | abort_c;
        timeout_flag_d = abort_c ? 1'b1 : (timeout_clear ? 1'b0 : timeout_flag_q);

        case (state_q)
            IDLE: begin
                if (act0_c | act1_c) begin
                    state_d       = BUSY;
                    busy_d        = 1'b1;
                    owner_d       = sel_c;
                    count_d       = '0;
                    m_address_d   = sel_c ? req1_address : req0_address;
                    m_writedata_d = sel_c ? req1_writedata : req0_writedata;
                    m_write_d     = sel_c ? req1_write : req0_write;
                    // Both strobes high is treated as a write
                    m_read_d      = sel_c ? (req1_read & ~req1_write) : (req0_read & ~req0_write);
                end
            end
            BUSY: begin
                if (fin_c) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    m_write_d = 1'b0;
                    m_read_d  = 1'b0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion routing back to the owning requester
    always_comb begin
        resp_c           = abort_c ? ABORT_RDATA : m_readdata;
        req0_waitrequest = act0_c & ~(fin_c & ~owner_q);
        req1_waitrequest = act1_c & ~(fin_c & owner_q);
        req0_readdata    = (fin_c & ~owner_q) ? resp_c : '0;
        req1_readdata    = (fin_c & owner_q) ? resp_c : '0;
    end

    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_write      = m_write_q;
    assign m_read       = m_read_q;
    assign owner        = owner_q;
    assign busy         = busy_q;
    assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_av_master_arbiter.sv
// Bench for av_master_arbiter: directed scenarios, then random traffic against a transaction-level model.
module tb_av_master_arbiter;
    logic        sysclk, sysreset;
    logic [15:0] req0_address, req0_writedata, req0_readdata;
    logic        req0_write, req0_read, req0_waitrequest;
    logic [15:0] req1_address, req1_writedata, req1_readdata;
    logic        req1_write, req1_read, req1_waitrequest;
    logic [15:0] m_address, m_writedata, m_readdata;
    logic        m_write, m_read, m_waitrequest;
    logic        owner, busy, timeout_flag, timeout_clear;

    int n_assert = 0;
    int n_fail   = 0;

    av_master_arbiter #(.TIMEOUT_CYCLES(8), .ABORT_RDATA(16'hDEAD)) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .req0_address(req0_address), .req0_writedata(req0_writedata),
        .req0_write(req0_write), .req0_read(req0_read),
        .req0_readdata(req0_readdata), .req0_waitrequest(req0_waitrequest),
        .req1_address(req1_address), .req1_writedata(req1_writedata),
        .req1_write(req1_write), .req1_read(req1_read),
        .req1_readdata(req1_readdata), .req1_waitrequest(req1_waitrequest),
        .m_address(m_address), .m_writedata(m_writedata),
        .m_write(m_write), .m_read(m_read),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .owner(owner), .busy(busy),
        .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
    );

    initial sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_write = 0; req0_read = 0; req1_write = 0; req1_read = 0;
    endtask

    // Random-phase model state
    logic [15:0] mem [0:7];
    bit          pend [2];
    int          op   [2];   // 0 read, 1 write, 2 both strobes (write)
    logic [15:0] ad   [2];
    logic [15:0] wd   [2];
    bit          mbusy, exp_flag, done, abt;
    int          cur, last, bcyc, w;
    logic [15:0] exp_rd;

    initial begin
        sysreset = 1; timeout_clear = 0; idle_inputs();
        req0_address = 0; req0_writedata = 0; req1_address = 0; req1_writedata = 0;
        m_readdata = 0; m_waitrequest = 0;
        #5;
        chk("rst_m_write", m_write, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_owner", owner, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tflag", timeout_flag, 0);
        tick(); tick();
        sysreset = 0;

        // Contention after reset: strict alternation starting with req0
        req0_write = 1; req0_address = 16'h00A0; req0_writedata = 16'h1111;
        req1_write = 1; req1_address = 16'h00B1; req1_writedata = 16'h2222;
        m_waitrequest = 0;
        #1;
        chk("t3_idle_wait0", req0_waitrequest, 1);
        chk("t3_idle_wait1", req1_waitrequest, 1);
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("t3_owner", owner, 32'(i % 2));
            chk("t3_addr", m_address, (i % 2) ? 32'h00B1 : 32'h00A0);
            chk("t3_m_write", m_write, 1);
            chk("t3_wait_owner", (i % 2) ? req1_waitrequest : req0_waitrequest, 0);
            chk("t3_wait_other", (i % 2) ? req0_waitrequest : req1_waitrequest, 1);
            tick();
            if (i == 7) idle_inputs();
            #1;
            chk("t3_idle", busy, 0);
        end

        // Zero-wait read from req0
        tick();
        req0_read = 1; req0_address = 16'h0010; m_readdata = 16'h1234; m_waitrequest = 0;
        #1;
        chk("t2_stall", req0_waitrequest, 1);
        tick(); #1;
        chk("t2_m_read", m_read, 1);
        chk("t2_addr", m_address, 16'h0010);
        chk("t2_wait", req0_waitrequest, 0);
        chk("t2_rdata", req0_readdata, 16'h1234);
        chk("t2_other_rdata", req1_readdata, 0);
        chk("t2_other_wait", req1_waitrequest, 0);
        tick(); req0_read = 0; #1;
        chk("t2_done_m_read", m_read, 0);
        chk("t2_done_busy", busy, 0);

        // Write from req1 with three wait states
        tick();
        req1_write = 1; req1_address = 16'h0001; req1_writedata = 16'h0041; m_waitrequest = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("t1_m_write", m_write, 1);
            chk("t1_wdata", m_writedata, 16'h0041);
            chk("t1_addr", m_address, 16'h0001);
            chk("t1_stall", req1_waitrequest, 1);
        end
        tick(); m_waitrequest = 0; #1;
        chk("t1_m_write4", m_write, 1);
        chk("t1_wait_low", req1_waitrequest, 0);
        tick(); req1_write = 0; #1;
        chk("t1_after", m_write, 0);
        chk("t1_after_busy", busy, 0);

        // Both strobes on req0 act as a write
        tick();
        req0_write = 1; req0_read = 1; req0_address = 16'h0020; req0_writedata = 16'h5555;
        #1;
        tick(); #1;
        chk("t6_m_write", m_write, 1);
        chk("t6_m_read", m_read, 0);
        tick(); idle_inputs(); #1;

        // Watchdog abort on a stuck read from req1
        tick();
        req1_read = 1; req1_address = 16'h0030; m_waitrequest = 1; m_readdata = 16'h7777;
        #1;
        for (int k = 0; k < 7; k++) begin
            tick(); #1;
            chk("t4_stall", req1_waitrequest, 1);
            chk("t4_rdata_zero", req1_readdata, 0);
        end
        tick(); #1;
        chk("t4_abort_wait", req1_waitrequest, 0);
        chk("t4_abort_rdata", req1_readdata, 16'hDEAD);
        chk("t4_flag_pre", timeout_flag, 0);
        tick(); req1_read = 0; #1;
        chk("t4_flag", timeout_flag, 1);
        chk("t4_busy", busy, 0);
        chk("t4_m_read", m_read, 0);
        tick(); #1;
        chk("t4_flag_sticky", timeout_flag, 1);
        tick(); timeout_clear = 1; #1;
        tick(); timeout_clear = 0; #1;
        chk("t4_flag_clr", timeout_flag, 0);

        // Async reset in the middle of a BUSY transfer
        tick();
        req0_write = 1; req0_address = 16'h0040; req0_writedata = 16'h0007; m_waitrequest = 1;
        #1;
        tick(); #1;
        chk("t5_m_write", m_write, 1);
        chk("t5_owner0", owner, 0);
        #2 sysreset = 1;
        #1;
        chk("t5_rst_m_write", m_write, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_owner", owner, 1);
        chk("t5_rst_wait", req0_waitrequest, 1);
        #2 sysreset = 0;
        tick(); #1;
        chk("t5_regrant", m_write, 1);
        chk("t5_regrant_owner", owner, 0);
        chk("t5_regrant_addr", m_address, 16'h0040);
        m_waitrequest = 0;
        tick(); idle_inputs(); #1;

        // Random traffic against the transaction-level model
        sysreset = 1; #3; sysreset = 0;
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        pend[0] = 0; pend[1] = 0; mbusy = 0; exp_flag = 0; last = 1; cur = 0; bcyc = 0; w = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(0, 2) == 0) begin
                    pend[n] = 1;
                    op[n]   = int'($urandom_range(0, 2));
                    ad[n]   = 16'($urandom_range(0, 7));
                    wd[n]   = 16'($urandom);
                end
            end
            req0_write = pend[0] && op[0] != 0; req0_read = pend[0] && op[0] != 1;
            req1_write = pend[1] && op[1] != 0; req1_read = pend[1] && op[1] != 1;
            req0_address = ad[0]; req0_writedata = wd[0];
            req1_address = ad[1]; req1_writedata = wd[1];
            timeout_clear = ($urandom_range(0, 3) == 0);
            if (mbusy && bcyc == 0) begin
                chk("rnd_owner", owner, 32'(cur));
                chk("rnd_addr", m_address, ad[cur]);
                chk("rnd_m_write", m_write, 32'(op[cur] != 0));
                chk("rnd_m_read", m_read, 32'(op[cur] == 0));
                if (op[cur] != 0) chk("rnd_wdata", m_writedata, wd[cur]);
                w = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
            end
            m_waitrequest = mbusy ? (bcyc < w) : 1'($urandom_range(0, 1));
            m_readdata    = mbusy ? mem[m_address[2:0]] : 16'($urandom);
            #1;
            chk("rnd_busy", busy, 32'(mbusy));
            chk("rnd_tflag", timeout_flag, 32'(exp_flag));
            done   = mbusy && (bcyc == w || bcyc == 7);
            abt    = mbusy && bcyc == 7 && w > 7;
            exp_rd = abt ? 16'hDEAD : mem[ad[cur][2:0]];
            chk("rnd_wait0", req0_waitrequest, 32'(pend[0] && !(done && cur == 0)));
            chk("rnd_wait1", req1_waitrequest, 32'(pend[1] && !(done && cur == 1)));
            chk("rnd_rdata0", req0_readdata, (done && cur == 0) ? 32'(exp_rd) : 32'h0);
            chk("rnd_rdata1", req1_readdata, (done && cur == 1) ? 32'(exp_rd) : 32'h0);
            exp_flag = abt ? 1'b1 : (timeout_clear ? 1'b0 : exp_flag);
            if (done) begin
                if (!abt && op[cur] != 0) mem[ad[cur][2:0]] = wd[cur];
                pend[cur] = 0;
                last  = cur;
                mbusy = 0;
            end else if (mbusy) begin
                bcyc++;
            end else if (pend[0] || pend[1]) begin
                cur   = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
                mbusy = 1;
                bcyc  = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
